// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared types and constants for the SRP16 ALU command sequencer.
//   cmd_kind_e : command encoding carried on cmd_kind (LD, LDU, OP, RD)
//   state_e    : sequencer states
//   ALU_NOP    : opcode that leaves the ALU untouched when no strobe is set
//   DEF_W/DEF_OPW : default operand and opcode widths
//   first_state() : state a freshly started command enters
package alu_ctrl_pkg;

  localparam int DEF_W   = 16;
  localparam int DEF_OPW = 5;

  localparam logic [4:0] ALU_NOP = 5'h00;

  typedef enum logic [1:0] {
    CMD_LD  = 2'd0,
    CMD_LDU = 2'd1,
    CMD_OP  = 2'd2,
    CMD_RD  = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_READ,
    ST_WAIT,
    ST_RESP
  } state_e;

  // A read-back skips the strobe cycle and goes straight to READ;
  // everything else needs one DRIVE cycle first.
  function automatic state_e first_state(input cmd_kind_e kind);
    return (kind == CMD_RD) ? ST_READ : ST_DRIVE;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if
// Bundles the command handshake, response handshake and ALU strobe bus
// of the sequencer.
//   slave  : the sequencer side (takes commands, drives the ALU, offers responses)
//   master : the environment side (decoder, response consumer and the ALU itself)
// Parameters W (operand width) and OPW (opcode width).
interface alu_ctrl_if
  import alu_ctrl_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int OPW = DEF_OPW
);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_kind;
  logic           cmd_rdbk;
  logic [OPW-1:0] cmd_op;
  logic [W-1:0]   cmd_data;

  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           res_flag;

  logic [OPW-1:0] alu_opcode;
  logic [W-1:0]   alu_operand;
  logic           alu_write;
  logic           alu_writeu;
  logic           alu_read;
  logic [W-1:0]   alu_accout;
  logic           alu_flag;

  logic           busy;

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rdbk, cmd_op, cmd_data,
    output cmd_ready,
    output res_valid, res_data, res_flag,
    input  res_ready,
    output alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
    input  alu_accout, alu_flag,
    output busy
  );

  modport master (
    output cmd_valid, cmd_kind, cmd_rdbk, cmd_op, cmd_data,
    input  cmd_ready,
    input  res_valid, res_data, res_flag,
    output res_ready,
    input  alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
    output alu_accout, alu_flag,
    input  busy
  );

endinterface

// File: rtl/alu_ctrl_skid.sv
// alu_ctrl_skid
// One-entry command buffer so a command can be taken while the sequencer
// is still busy. Only built when ALU_CTRL_SKID_EN is defined.
//   clk, rst_n        : clock, asynchronous active-low reset (clears the entry)
//   push_i            : store kind_i/rdbk_i/op_i/data_i
//   pop_i             : release the held entry
//   valid_o           : entry held
//   kind_o..data_o    : held command fields
module alu_ctrl_skid
  import alu_ctrl_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int OPW = DEF_OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic           pop_i,
  input  cmd_kind_e      kind_i,
  input  logic           rdbk_i,
  input  logic [OPW-1:0] op_i,
  input  logic [W-1:0]   data_i,
  output logic           valid_o,
  output cmd_kind_e      kind_o,
  output logic           rdbk_o,
  output logic [OPW-1:0] op_o,
  output logic [W-1:0]   data_o
);

  logic           valid_q;
  cmd_kind_e      kind_q;
  logic           rdbk_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   data_q;

  // Push only happens while empty and pop only while full, so the two
  // never collide; push is listed last so it would win regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      kind_q  <= CMD_LD;
      rdbk_q  <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      if (pop_i) valid_q <= 1'b0;
      if (push_i) begin
        valid_q <= 1'b1;
        kind_q  <= kind_i;
        rdbk_q  <= rdbk_i;
        op_q    <= op_i;
        data_q  <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign kind_o  = kind_q;
  assign rdbk_o  = rdbk_q;
  assign op_o    = op_q;
  assign data_o  = data_q;

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl
// Command sequencer for the SRP16 accumulator ALU. Turns LD/LDU/OP/RD
// commands into the registered write/writeu/read/opcode/operand strobe
// pattern of the ALU and holds the read-back result until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_ctrl_if.slave - command handshake, response handshake,
//                ALU strobes/result, busy
// Build option: ALU_CTRL_SKID_EN adds a one-entry command buffer so
// back-to-back LD/LDU/OP commands issue one per cycle.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int OPW = DEF_OPW
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_ctrl_if.slave bus
);

  state_e         state_q, state_d;
  cmd_kind_e      kind_q, kind_d;
  logic           rdbk_q, rdbk_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   data_q, data_d;

  logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
  logic [W-1:0]   alu_operand_q, alu_operand_d;
  logic           alu_write_q, alu_write_d;
  logic           alu_writeu_q, alu_writeu_d;
  logic           alu_read_q, alu_read_d;

  logic [W-1:0]   res_data_q;
  logic           res_flag_q;

  logic           cmd_ready;
  logic           cmd_accept;
  logic           leave;
  cmd_kind_e      in_kind;
  logic           in_rdbk;

  logic           skid_valid;
  cmd_kind_e      skid_kind;
  logic           skid_rdbk;
  logic [OPW-1:0] skid_op;
  logic [W-1:0]   skid_data;

  assign cmd_accept = bus.cmd_valid & cmd_ready;
  assign in_kind    = cmd_kind_e'(bus.cmd_kind);
  // rdbk only means something for OP; masking it here keeps LD/LDU from
  // ever wandering into READ.
  assign in_rdbk    = bus.cmd_rdbk & (in_kind == CMD_OP);

  // The sequencer is free to start a new command this cycle: it is idle,
  // finishing a DRIVE with no read-back, or retiring a response.
  assign leave = (state_q == ST_IDLE)
               | ((state_q == ST_DRIVE) & ~rdbk_q)
               | ((state_q == ST_RESP) & bus.res_ready);

`ifdef ALU_CTRL_SKID_EN
  logic skid_push;
  logic skid_pop;

  // Take a command whenever the buffer is empty; it bypasses the buffer
  // if the sequencer can start it right away, otherwise it is parked.
  assign cmd_ready = ~skid_valid;
  assign skid_push = cmd_accept & ~leave;
  assign skid_pop  = leave & skid_valid;

  alu_ctrl_skid #(
    .W   (W),
    .OPW (OPW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .kind_i  (in_kind),
    .rdbk_i  (in_rdbk),
    .op_i    (bus.cmd_op),
    .data_i  (bus.cmd_data),
    .valid_o (skid_valid),
    .kind_o  (skid_kind),
    .rdbk_o  (skid_rdbk),
    .op_o    (skid_op),
    .data_o  (skid_data)
  );
`else
  assign cmd_ready  = (state_q == ST_IDLE);
  assign skid_valid = 1'b0;
  assign skid_kind  = CMD_LD;
  assign skid_rdbk  = 1'b0;
  assign skid_op    = '0;
  assign skid_data  = '0;
`endif

  // Next-state logic: walk DRIVE -> READ -> WAIT -> RESP as needed, and
  // whenever the sequencer becomes free pick the next command, giving the
  // buffered one priority over the bus.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rdbk_d  = rdbk_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      ST_DRIVE: if (rdbk_q) state_d = ST_READ;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      default:  state_d = state_q;
    endcase
    if (leave) begin
      state_d = ST_IDLE;
      if (skid_valid) begin
        state_d = first_state(skid_kind);
        kind_d  = skid_kind;
        rdbk_d  = skid_rdbk;
        op_d    = skid_op;
        data_d  = skid_data;
      end else if (cmd_accept) begin
        state_d = first_state(in_kind);
        kind_d  = in_kind;
        rdbk_d  = in_rdbk;
        op_d    = bus.cmd_op;
        data_d  = bus.cmd_data;
      end
    end
  end

  // ALU strobes are computed from the state being entered so that they
  // can be registered and still line up exactly with that state.
  always_comb begin
    alu_opcode_d  = OPW'(ALU_NOP);
    alu_operand_d = '0;
    alu_write_d   = 1'b0;
    alu_writeu_d  = 1'b0;
    alu_read_d    = 1'b0;
    if (state_d == ST_DRIVE) begin
      alu_operand_d = data_d;
      alu_write_d   = (kind_d == CMD_LD);
      alu_writeu_d  = (kind_d == CMD_LDU);
      if (kind_d == CMD_OP) alu_opcode_d = op_d;
    end else if (state_d == ST_READ) begin
      alu_read_d = 1'b1;
    end
  end

  // State, latched command, registered ALU strobes and the held response.
  // The result is sampled on the edge that ends WAIT, one cycle after the
  // read strobe, when the ALU output has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      kind_q        <= CMD_LD;
      rdbk_q        <= 1'b0;
      op_q          <= '0;
      data_q        <= '0;
      alu_opcode_q  <= '0;
      alu_operand_q <= '0;
      alu_write_q   <= 1'b0;
      alu_writeu_q  <= 1'b0;
      alu_read_q    <= 1'b0;
      res_data_q    <= '0;
      res_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      rdbk_q        <= rdbk_d;
      op_q          <= op_d;
      data_q        <= data_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_operand_q <= alu_operand_d;
      alu_write_q   <= alu_write_d;
      alu_writeu_q  <= alu_writeu_d;
      alu_read_q    <= alu_read_d;
      if (state_q == ST_WAIT) begin
        res_data_q <= bus.alu_accout;
        res_flag_q <= bus.alu_flag;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.res_valid   = (state_q == ST_RESP);
  assign bus.res_data    = res_data_q;
  assign bus.res_flag    = res_flag_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_operand = alu_operand_q;
  assign bus.alu_write   = alu_write_q;
  assign bus.alu_writeu  = alu_writeu_q;
  assign bus.alu_read    = alu_read_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl
// Directed bench for alu_ctrl with a small accumulator ALU model:
// write loads acc (flag cleared), writeu loads acc[15:8] from operand[7:0],
// opcode 02 adds operand (flag = carry), opcode 0E increments (flag = carry).
module tb_alu_ctrl;

  logic clk;
  logic rst_n;

  alu_ctrl_if #(.W(16), .OPW(5)) bus ();

  alu_ctrl #(.W(16), .OPW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount;
  int passCount;

  logic [15:0] accReg;
  logic        flagReg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, acting on the registered strobes at each rising edge.
  always @(posedge clk) begin
    if (bus.alu_write) begin
      accReg  <= bus.alu_operand;
      flagReg <= 1'b0;
    end else if (bus.alu_writeu) begin
      accReg[15:8] <= bus.alu_operand[7:0];
    end else if (bus.alu_opcode == 5'h02) begin
      {flagReg, accReg} <= {1'b0, accReg} + {1'b0, bus.alu_operand};
    end else if (bus.alu_opcode == 5'h0E) begin
      {flagReg, accReg} <= {1'b0, accReg} + 17'd1;
    end
  end

  assign bus.alu_accout = accReg;
  assign bus.alu_flag   = flagReg;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    else
      passCount++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, wait (bounded) until it is taken, and return 1ns
  // after the accepting edge with cmd_valid dropped.
  task automatic applyStimulus(input logic [1:0] kind, input logic rdbk,
                               input logic [4:0] op, input logic [15:0] data);
    int waitCycles;
    bus.cmd_kind  = kind;
    bus.cmd_rdbk  = rdbk;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    waitCycles = 0;
    while (!bus.cmd_ready && waitCycles < 20) begin
      step();
      waitCycles++;
    end
    if (!bus.cmd_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic retire();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checkOutput("retire_res_valid", bus.res_valid, 0);
    checkOutput("retire_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  logic [15:0] ldData[4];
  logic        expWr[8];
  logic [15:0] expOperand[8];
  logic        rdy;
  int          issued;

  initial begin
    checkCount    = 0;
    passCount     = 0;
    accReg        = 16'h0000;
    flagReg       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 2'd0;
    bus.cmd_rdbk  = 1'b0;
    bus.cmd_op    = 5'd0;
    bus.cmd_data  = 16'h0000;
    bus.res_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) step();

    // Reset values
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_res_data", bus.res_data, 0);
    checkOutput("rst_res_flag", bus.res_flag, 0);
    checkOutput("rst_alu_write", bus.alu_write, 0);
    checkOutput("rst_alu_read", bus.alu_read, 0);
    checkOutput("rst_alu_opcode", bus.alu_opcode, 0);
    rst_n = 1'b1;
    step();

    // LD FFFE then RD
    applyStimulus(2'd0, 1'b0, 5'd0, 16'hFFFE);
    checkOutput("ld_write", bus.alu_write, 1);
    checkOutput("ld_operand", bus.alu_operand, 16'hFFFE);
    checkOutput("ld_opcode", bus.alu_opcode, 0);
    checkOutput("ld_cmd_ready", bus.cmd_ready, 0);
    checkOutput("ld_busy", bus.busy, 1);
    step();
    checkOutput("ld_write_done", bus.alu_write, 0);
    checkOutput("ld_ready_back", bus.cmd_ready, 1);
    applyStimulus(2'd3, 1'b0, 5'd0, 16'h0000);
    checkOutput("rd_read", bus.alu_read, 1);
    checkOutput("rd_operand", bus.alu_operand, 0);
    checkOutput("rd_res_valid0", bus.res_valid, 0);
    step();
    checkOutput("rd_wait_read", bus.alu_read, 0);
    checkOutput("rd_res_valid1", bus.res_valid, 0);
    step();
    checkOutput("rd_res_valid2", bus.res_valid, 1);
    checkOutput("rd_res_data", bus.res_data, 16'hFFFE);
    checkOutput("rd_res_flag", bus.res_flag, 0);
    retire();

    // Reset asserted while in READ
    applyStimulus(2'd3, 1'b0, 5'd0, 16'h0000);
    checkOutput("mid_read", bus.alu_read, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_read", bus.alu_read, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("mid_rst_res_data", bus.res_data, 0);
    checkOutput("mid_rst_res_valid", bus.res_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_cmd_ready", bus.cmd_ready, 1);
    step();
    checkOutput("post_rst_res_valid", bus.res_valid, 0);
    checkOutput("post_rst_busy", bus.busy, 0);

    // LD FFFE, OP add 5 with read-back: FFFE + 5 = 0003 carry 1
    applyStimulus(2'd0, 1'b0, 5'd0, 16'hFFFE);
    step();
    applyStimulus(2'd2, 1'b1, 5'h02, 16'h0005);
    checkOutput("op_opcode", bus.alu_opcode, 5'h02);
    checkOutput("op_operand", bus.alu_operand, 16'h0005);
    checkOutput("op_write", bus.alu_write, 0);
    checkOutput("op_read0", bus.alu_read, 0);
    step();
    checkOutput("op_opcode_gone", bus.alu_opcode, 0);
    checkOutput("op_read1", bus.alu_read, 1);
    step();
    checkOutput("op_read2", bus.alu_read, 0);
    checkOutput("op_res_valid_wait", bus.res_valid, 0);
    step();
    checkOutput("op_res_valid", bus.res_valid, 1);
    checkOutput("op_res_data", bus.res_data, 16'h0003);
    checkOutput("op_res_flag", bus.res_flag, 1);
    retire();

    // LD FFFF, OP inc with read-back, response held for 5 cycles
    applyStimulus(2'd0, 1'b0, 5'd0, 16'hFFFF);
    step();
    applyStimulus(2'd2, 1'b1, 5'h0E, 16'h0000);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_res_valid", bus.res_valid, 1);
      checkOutput("hold_res_data", bus.res_data, 16'h0000);
      checkOutput("hold_res_flag", bus.res_flag, 1);
`ifndef ALU_CTRL_SKID_EN
      checkOutput("hold_cmd_ready", bus.cmd_ready, 0);
`endif
      step();
    end
    retire();

    // LDU 12AB: only writeu strobes, no response
    applyStimulus(2'd1, 1'b0, 5'd0, 16'h12AB);
    checkOutput("ldu_writeu", bus.alu_writeu, 1);
    checkOutput("ldu_write", bus.alu_write, 0);
    checkOutput("ldu_read", bus.alu_read, 0);
    checkOutput("ldu_operand", bus.alu_operand, 16'h12AB);
    step();
    checkOutput("ldu_writeu_done", bus.alu_writeu, 0);
    step();
    checkOutput("ldu_no_resp", bus.res_valid, 0);

    // Back-to-back LDs with cmd_valid held high
    ldData = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`ifdef ALU_CTRL_SKID_EN
    expWr      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    expOperand = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
`else
    expWr      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    expOperand = '{16'h1111, 16'h0, 16'h2222, 16'h0, 16'h3333, 16'h0, 16'h4444, 16'h0};
`endif
    bus.cmd_kind  = 2'd0;
    bus.cmd_rdbk  = 1'b0;
    bus.cmd_op    = 5'd0;
    bus.cmd_data  = ldData[0];
    bus.cmd_valid = 1'b1;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      rdy = bus.cmd_ready;
      step();
      if (rdy && bus.cmd_valid) begin
        issued++;
        if (issued == 4) bus.cmd_valid = 1'b0;
        else bus.cmd_data = ldData[issued];
      end
      checkOutput($sformatf("b2b_write%0d", c), bus.alu_write, expWr[c]);
      checkOutput($sformatf("b2b_operand%0d", c), bus.alu_operand, expOperand[c]);
    end
    bus.cmd_valid = 1'b0;

    // Read back the last loaded value
    applyStimulus(2'd3, 1'b0, 5'd0, 16'h0000);
    repeat (2) step();
    checkOutput("b2b_res_valid", bus.res_valid, 1);
    checkOutput("b2b_res_data", bus.res_data, 16'h4444);
    retire();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Command sequencer for the SRP16 accumulator ALU. It accepts load, load-upper, execute and read-back commands over a valid/ready handshake and turns each into the cycle-exact `write`/`writeu`/`read`/`opcode`/`operand` strobe pattern the ALU needs. It captures `accout` and `flag` into a held response. It sits between the instruction decoder and the ALU, so the ALU is driven only through this block.

## Interface
- `W`, default 16: operand and accumulator width.
- `OPW`, default 5: ALU opcode width; opcode 0 is NOP/pass.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_kind` in 2: 0 LD, 1 LDU, 2 OP, 3 RD.
- `cmd_rdbk` in 1: OP only; append a read-back and respond.
- `cmd_op` in OPW: ALU opcode for OP.
- `cmd_data` in W: operand for LD/LDU/OP.
- `res_valid` out 1: response held until accepted.
- `res_ready` in 1: response consumer ready.
- `res_data` out W: captured `accout`.
- `res_flag` out 1: captured `flag`.
- `alu_opcode` out OPW: to ALU `opcode`.
- `alu_operand` out W: to ALU `operand`.
- `alu_write` out 1: to ALU `write`.
- `alu_writeu` out 1: to ALU `writeu`.
- `alu_read` out 1: to ALU `read`.
- `alu_accout` in W: from ALU.
- `alu_flag` in 1: from ALU.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, DRIVE, READ, WAIT, RESP.
- IDLE: `cmd_ready` is 1.
  - On accept, latch kind, rdbk, op and data, then go to DRIVE.
  - RD goes directly to READ.
- DRIVE: exactly one cycle of strobes.
  - LD: `alu_write`=1, `alu_opcode`=0, `alu_operand`=data.
  - LDU: `alu_writeu`=1, `alu_opcode`=0, `alu_operand`=data.
  - OP: `alu_opcode`=op, `alu_operand`=data, all strobes 0.
  - Next state is IDLE, or READ if `rdbk` is set.
- READ: `alu_read`=1, `alu_opcode`=0, `alu_operand`=0; next state WAIT.
- WAIT: no strobes. At the edge ending WAIT, capture `alu_accout` into `res_data` and `alu_flag` into `res_flag`; go to RESP.
- RESP: `res_valid`=1, with `res_data`/`res_flag` stable. On `res_ready`, go to IDLE.
- Outside DRIVE and READ, all ALU outputs are 0. Opcode 0 with no strobe means the ALU holds its state.
- LD, LDU and OP without rdbk produce no response.
- Unknown `cmd_kind` cannot occur: the 2-bit field is fully decoded.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `res_valid`=0, `res_data`=0, `res_flag`=0, all `alu_*` outputs 0, state IDLE.
- LD/LDU/OP: accept at edge E; strobes during cycle E..E+1; ALU acts at edge E+1; `cmd_ready` returns at E+1.
- RD: accept at E; READ during E..E+1; WAIT during E+1..E+2; `res_valid` from E+2.
- OP+rdbk: as RD shifted one cycle later; `res_valid` from E+3.
- Throughput without skid: one LD/LDU/OP every 2 cycles.
- `res_valid` and `res_ready` both high at edge R: response retires at R; `cmd_ready` is high in the following cycle.
- `rst_n` low mid-sequence: immediately force the reset values and drop any in-flight strobe and response. ALU contents are then undefined to software.
- All `alu_*` outputs are registered; no combinational path from `cmd_*` to `alu_*`.

## Configuration
- `ALU_CTRL_SKID_EN` defined: adds a one-entry command buffer.
  - `cmd_ready` = buffer empty, so a command can be accepted while busy.
  - On leaving DRIVE to IDLE or RESP to IDLE with the buffer full, go straight to the buffered command's first state.
  - Back-to-back LD/LDU/OP then issue one per cycle.
  - Buffer is cleared on reset.
- Undefined: no buffer; `cmd_ready` = (state==IDLE).

## Structure
- Package `alu_ctrl_pkg` holds:
  - `cmd_kind_e` (LD, LDU, OP, RD);
  - `state_e`;
  - `ALU_NOP` = 5'h00;
  - `W`/`OPW` defaults.
- Sub-module `alu_ctrl_skid`: 1-entry valid/data register holding the command fields. It is instantiated only under `ALU_CTRL_SKID_EN`.

## Test plan
- Reset: `rst_n`=0 mid-READ → all outputs are at reset values in the same cycle, `cmd_ready`=1 after release.
- LD 16'hFFFE then RD → `alu_write` pulses for one cycle with operand FFFE; `res_data`=16'hFFFE, `res_valid` 2 cycles after RD accept.
- LD 16'hFFFE, OP op=5'b00010 data=16'h0005 with rdbk → `alu_opcode`=02 for exactly one cycle, then `alu_read` for one cycle; `res_data`/`res_flag` equal the ALU model's result.
- LD 16'hFFFF, OP op=5'b01110 data=0 with rdbk, `res_ready` held low 5 cycles → `res_valid` and data stable, `cmd_ready`=0 throughout; retire on `res_ready`.
- LDU 16'h12AB → only `alu_writeu` strobes; `alu_write` and `alu_read` stay 0; no response.
- With `ALU_CTRL_SKID_EN`: 4 back-to-back LDs with `cmd_valid` held high → `alu_write` high in consecutive cycles with the operands in order; without the macro → one LD every 2 cycles.
